// File: rtl/sram_mem_arbiter.sv
// sram_mem_arbiter: round-robin two-requester arbiter onto a single-port synchronous SRAM
module sram_mem_arbiter #(
  parameter int ADDR_BW_p = 16,
  parameter int DATA_BW_p = 32,
  parameter int SRAM_DEPTH_p = 4096,
  localparam int SRAM_AW = $clog2(SRAM_DEPTH_p)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     req_valid_i,
  input  logic [1:0][ADDR_BW_p-1:0]      req_addr_i,
  input  logic [1:0][DATA_BW_p-1:0]      req_wdata_i,
  input  logic [1:0][3:0]                req_wstrb_i,
  output logic [1:0]                     req_ready_o,
  output logic [DATA_BW_p-1:0]           req_rdata_o,
  output logic                           sram_en_o,
  output logic [3:0]                     sram_we_o,
  output logic [SRAM_AW-1:0]             sram_addr_o,
  output logic [DATA_BW_p-1:0]           sram_wdata_o,
  input  logic [DATA_BW_p-1:0]           sram_rdata_i,
  output logic [1:0]                     grant_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic rr_q, win, win_q, grant, acc, rsp, rd;
  logic [SRAM_AW-1:0] addr_q;
  logic [DATA_BW_p-1:0] wdata_q, rdata_q;
  logic [3:0] wstrb_q;
  logic [1:0] owner;
  logic unused_addr;
  assign unused_addr = ^req_addr_i;
  assign win = &req_valid_i ? rr_q : req_valid_i[1];
  assign grant = state_q == IDLE && |req_valid_i;
  assign acc = state_q == ACCESS;
  assign rsp = state_q == RESP;
  assign rd = rsp && ~|wstrb_q;
  assign owner = win_q ? 2'b10 : 2'b01;
  assign sram_en_o = acc;
  assign sram_we_o = acc ? wstrb_q : '0;
  assign sram_addr_o = acc ? addr_q : '0;
  assign sram_wdata_o = acc ? wdata_q : '0;
  assign req_ready_o = rsp ? owner : 2'b00;
  assign grant_o = acc || rsp ? owner : 2'b00;
  assign req_rdata_o = rd ? sram_rdata_i : rdata_q;
  always_comb begin
    state_d = state_q == IDLE ? (|req_valid_i ? ACCESS : IDLE) : state_q == ACCESS ? RESP : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      win_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        rr_q <= ~win;
        win_q <= win;
        addr_q <= req_addr_i[win][SRAM_AW+1:2];
        wdata_q <= req_wdata_i[win];
        wstrb_q <= req_wstrb_i[win];
      end
      if (rd) rdata_q <= sram_rdata_i;
    end
  end
endmodule

// File: tb/tb_sram_mem_arbiter.sv
// tb_sram_mem_arbiter: table-driven and scoreboarded checks of the SRAM arbiter
module tb_sram_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid_i = '0;
  logic [1:0][15:0] req_addr_i = '0;
  logic [1:0][31:0] req_wdata_i = '0;
  logic [1:0][3:0] req_wstrb_i = '0;
  logic [1:0] req_ready_o, grant_o;
  logic [31:0] req_rdata_o, sram_wdata_o, sram_rdata_i = '0;
  logic sram_en_o;
  logic [3:0] sram_we_o;
  logic [11:0] sram_addr_o;
  int checks = 0, failures = 0;
  logic [31:0] last_rd = '0;
  typedef struct {
    logic [1:0] valid; logic [15:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
    logic [31:0] srd; logic [1:0] grant; logic [11:0] waddr;
  } vec_t;
  typedef struct {
    logic [1:0] ready; logic [31:0] rdata; logic [11:0] addr; logic [3:0] we; logic [31:0] wdata; logic [31:0] hold;
  } exp_t;
  exp_t sb[$];
  vec_t vt[8];
  sram_mem_arbiter dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i), .req_ready_o(req_ready_o),
    .req_rdata_o(req_rdata_o), .sram_en_o(sram_en_o), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
    .grant_o(grant_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_valid_i = '0;
    last_rd = '0;
    repeat (2) @(negedge clk);
    chk("rst_en", {31'b0, sram_en_o}, 0);
    chk("rst_ready", {30'b0, req_ready_o}, 0);
    chk("rst_grant", {30'b0, grant_o}, 0);
    chk("rst_rdata", req_rdata_o, 0);
    rst = 1'b0;
  endtask
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    bit done = 0;
    int w = v.grant[1] ? 1 : 0;
    @(negedge clk);
    req_valid_i = v.valid;
    req_addr_i[w] = v.addr;
    req_addr_i[1-w] = ~v.addr;
    req_wdata_i[w] = v.wdata;
    req_wdata_i[1-w] = ~v.wdata;
    req_wstrb_i[w] = v.wstrb;
    req_wstrb_i[1-w] = ~v.wstrb;
    sram_rdata_i = v.srd;
    e = '{ready: v.grant, rdata: (v.wstrb == 0 ? v.srd : last_rd), addr: v.waddr, we: v.wstrb, wdata: v.wdata, hold: last_rd};
    if (v.wstrb == 0) last_rd = v.srd;
    sb.push_back(e);
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge clk);
      if (sram_en_o) begin
        chk({tag, "_acc_cycle"}, c, 1);
        chk({tag, "_addr"}, {20'b0, sram_addr_o}, {20'b0, sb[0].addr});
        chk({tag, "_we"}, {28'b0, sram_we_o}, {28'b0, sb[0].we});
        chk({tag, "_wdata"}, sram_wdata_o, sb[0].wdata);
        chk({tag, "_acc_grant"}, {30'b0, grant_o}, {30'b0, sb[0].ready});
        chk({tag, "_hold"}, req_rdata_o, sb[0].hold);
      end
      if (req_ready_o != 0) begin
        e = sb.pop_front();
        chk({tag, "_rsp_cycle"}, c, 2);
        chk({tag, "_ready"}, {30'b0, req_ready_o}, {30'b0, e.ready});
        chk({tag, "_rdata"}, req_rdata_o, e.rdata);
        chk({tag, "_rsp_grant"}, {30'b0, grant_o}, {30'b0, e.ready});
        req_valid_i = '0;
        done = 1;
      end
    end
    if (!done) begin
      chk({tag, "_timeout"}, 0, 1);
      sb.delete();
      req_valid_i = '0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    int k;
    vt[0] = '{2'b01, 16'h0010, 32'h0, 4'b0000, 32'hDEADBEEF, 2'b01, 12'h004};
    vt[1] = '{2'b10, 16'h0008, 32'h0, 4'b0000, 32'hA5A5A5A5, 2'b10, 12'h002};
    vt[2] = '{2'b10, 16'h4004, 32'h12345678, 4'b0011, 32'hFFFFFFFF, 2'b10, 12'h001};
    vt[3] = '{2'b11, 16'h0FFC, 32'h0, 4'b0000, 32'h11112222, 2'b01, 12'h3FF};
    vt[4] = '{2'b11, 16'h3FFC, 32'hCAFEF00D, 4'b1111, 32'h00000000, 2'b10, 12'hFFF};
    vt[5] = '{2'b01, 16'hFFFC, 32'h0, 4'b0000, 32'h0BADC0DE, 2'b01, 12'hFFF};
    vt[6] = '{2'b11, 16'h0001, 32'h87654321, 4'b1000, 32'h0, 2'b10, 12'h000};
    vt[7] = '{2'b11, 16'h0022, 32'h0, 4'b0000, 32'h5555AAAA, 2'b01, 12'h008};
    do_reset();
    for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));
    do_reset();
    @(negedge clk);
    req_valid_i = 2'b11;
    req_addr_i[0] = 16'h0020;
    req_addr_i[1] = 16'h0040;
    req_wstrb_i = '0;
    sram_rdata_i = 32'h13572468;
    for (int j = 0; j < 4; j++) sb.push_back('{ready: (j % 2 == 0 ? 2'b01 : 2'b10), rdata: 32'h13572468, addr: (j % 2 == 0 ? 12'h008 : 12'h010), we: 4'b0, wdata: 32'h0, hold: 32'h0});
    for (int c = 1; c <= 14 && sb.size() != 0; c++) begin
      @(negedge clk);
      if (sram_en_o) chk("rr_addr", {20'b0, sram_addr_o}, {20'b0, sb[0].addr});
      if (req_ready_o != 0) begin
        k = 4 - sb.size();
        e = sb.pop_front();
        chk("rr_cycle", c, 2 + 3 * k);
        chk("rr_ready", {30'b0, req_ready_o}, {30'b0, e.ready});
        chk("rr_rdata", req_rdata_o, e.rdata);
        if (k == 3) req_valid_i = '0;
      end
    end
    chk("rr_drain", sb.size(), 0);
    sb.delete();
    req_valid_i = '0;
    last_rd = 32'h13572468;
    @(negedge clk);
    req_valid_i = 2'b01;
    req_addr_i[0] = 16'h0030;
    req_wdata_i[0] = 32'h00000055;
    req_wstrb_i[0] = 4'b1111;
    @(negedge clk);
    chk("abort_en_before", {31'b0, sram_en_o}, 1);
    chk("abort_we_before", {28'b0, sram_we_o}, 32'hF);
    #2 rst = 1'b1;
    req_valid_i = '0;
    last_rd = '0;
    #1;
    chk("abort_en", {31'b0, sram_en_o}, 0);
    chk("abort_we", {28'b0, sram_we_o}, 0);
    chk("abort_grant", {30'b0, grant_o}, 0);
    chk("abort_rdata", req_rdata_o, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_ready", {30'b0, req_ready_o}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle_ready", {30'b0, req_ready_o}, 0);
    run_vec('{2'b11, 16'h0050, 32'h0, 4'b0000, 32'h2468ACE0, 2'b01, 12'h014}, "post_rst");
    @(negedge clk);
    req_valid_i = 2'b01;
    req_addr_i[0] = 16'h0100;
    req_wstrb_i[0] = 4'b0000;
    sram_rdata_i = 32'h00000077;
    @(posedge clk);
    #1 req_valid_i = '0;
    @(negedge clk);
    chk("drop_en", {31'b0, sram_en_o}, 1);
    chk("drop_addr", {20'b0, sram_addr_o}, 32'h040);
    @(negedge clk);
    chk("drop_ready", {30'b0, req_ready_o}, 1);
    chk("drop_rdata", req_rdata_o, 32'h77);
    @(negedge clk);
    chk("drop_idle_grant", {30'b0, grant_o}, 0);
    chk("drop_idle_ready", {30'b0, req_ready_o}, 0);
    chk("drop_idle_en", {31'b0, sram_en_o}, 0);
    chk("drop_idle_rdata", req_rdata_o, 32'h77);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_mem_arbiter.md
SRAM_MEM_ARBITER -- requirements
Module: sram_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BW_p, default 16, byte-address width of each requester.
REQ-002 SHALL have parameter DATA_BW_p, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter SRAM_DEPTH_p, default 4096, SRAM depth in words; SRAM_AW = $clog2(SRAM_DEPTH_p).
REQ-004 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid_i  input  [1:0]  per-requester transaction request; index 0 is the CPU, index 1 is the loader/DMA.
REQ-007 SHALL have port req_addr_i  input  [1:0][ADDR_BW_p-1:0]  byte address per requester.
REQ-008 SHALL have port req_wdata_i  input  [1:0][DATA_BW_p-1:0]  write data per requester.
REQ-009 SHALL have port req_wstrb_i  input  [1:0][3:0]  byte write strobes; 4'b0000 means read.
REQ-010 SHALL have port req_ready_o  output  [1:0]  one-cycle completion pulse per requester.
REQ-011 SHALL have port req_rdata_o  output  [DATA_BW_p-1:0]  read data shared by both requesters.
REQ-012 SHALL have port sram_en_o  output  1  SRAM access enable.
REQ-013 SHALL have port sram_we_o  output  [3:0]  SRAM byte write enables.
REQ-014 SHALL have port sram_addr_o  output  [SRAM_AW-1:0]  SRAM word address.
REQ-015 SHALL have port sram_wdata_o  output  [DATA_BW_p-1:0]  SRAM write data.
REQ-016 SHALL have port sram_rdata_i  input  [DATA_BW_p-1:0]  SRAM read data, valid exactly one cycle after sram_en_o with sram_we_o == 0.
REQ-017 SHALL have port grant_o  output  [1:0]  one-hot owner of the in-flight transaction; 2'b00 when idle.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS when any req_valid_i is high, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-019 In IDLE with valid requests, SHALL select a winner round-robin:
- if only one request is valid, that requester wins;
- if both are valid, the requester named by priority pointer rr_q wins.
REQ-020 On a grant, SHALL set rr_q to the index that did not win.
REQ-021 On the IDLE->ACCESS edge, SHALL capture into registers:
- the winner index;
- the word address req_addr_i[winner][SRAM_AW+1:2], with upper bits and bits [1:0] ignored so the address wraps modulo the SRAM depth;
- the winner's wdata and wstrb.
REQ-022 In ACCESS, SHALL drive sram_en_o=1, sram_we_o=captured wstrb, sram_addr_o=captured address and sram_wdata_o=captured wdata; all four SHALL be 0 in every other state.
REQ-023 In RESP, SHALL drive req_ready_o[winner]=1 for exactly one cycle; req_ready_o SHALL be 2'b00 in every other cycle.
REQ-024 In RESP of a read, SHALL drive req_rdata_o = sram_rdata_i and latch that value.
REQ-025 Outside RESP of a read, req_rdata_o SHALL hold the last latched read value, so that writes never disturb it.
REQ-026 Latency SHALL be: valid sampled in IDLE at cycle 0, sram_en_o high in cycle 1, req_ready_o high in cycle 2, IDLE again in cycle 3; one transaction SHALL complete per 3 cycles.
REQ-027 grant_o SHALL be one-hot for the winner during ACCESS and RESP.
REQ-028 Starvation bound: a continuously asserted request SHALL be granted within at most one intervening transaction of the other requester.
REQ-029 Requesters hold valid and payload until ready. If valid drops after the grant, the captured transaction SHALL still complete and pulse ready.
REQ-030 A requester whose valid is still high in the cycle ready pulses SHALL be treated as a new request in the following IDLE cycle.

Reset
REQ-031 While rst=1, asynchronously and independent of clk, SHALL force:
- state to IDLE;
- rr_q to 0;
- the latched rdata to 0;
- all outputs to 0.
REQ-032 Reset asserted during ACCESS or RESP SHALL abort the transaction: sram_en_o and req_ready_o deassert immediately and no ready pulse follows.
REQ-033 After rst deasserts, the first arbitration SHALL occur on the first rising edge with any req_valid_i high.

Verification
REQ-034 Reset, then req 0 reads address 16'h0010 with sram_rdata_i=32'hDEADBEEF -> sram_en_o=1 and sram_addr_o=4 in cycle 1, and req_ready_o=2'b01 with req_rdata_o=32'hDEADBEEF in cycle 2.
REQ-035 Both requesters valid from reset, held for 4 transactions -> grants alternate 0,1,0,1 with ready pulses at cycles 2,5,8,11.
REQ-036 Req 1 writes wstrb=4'b0011, wdata=32'h12345678 to 16'h4004, after an earlier read returned 32'hA5A5A5A5 -> in ACCESS sram_we_o=4'b0011, sram_addr_o=12'h001 (wrapped), and req_rdata_o stays 32'hA5A5A5A5.
REQ-037 rst asserted in ACCESS of a write -> sram_en_o drops in the same cycle, no req_ready_o pulse, and after release the next grant goes to req 0.
REQ-038 Req 0 drops valid during ACCESS -> req_ready_o[0] still pulses in RESP, and the FSM returns to IDLE with grant_o=2'b00.
